// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scanned 4x4 matrix keypad reader. Drives one column low at a time, samples
// the active-low rows through a two-flop synchronizer, assembles a 16-bit
// frame per full scan, debounces over whole frames and reports each distinct
// press once.
//
// Parameters:
//   SCAN_DIV       clock cycles each column is driven (>= 4)
//   DEBOUNCE_SCANS identical consecutive frames needed to accept press/release (1..15)
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   row[3:0]   keypad rows, active-low, asynchronous to clk
//   col[3:0]   keypad columns, active-low, exactly one bit low
//   key[3:0]   last accepted key code {col_idx, row_idx}
//   key_valid  one-cycle pulse when a new press is accepted
//   key_held   high from acceptance until the release is accepted
module keypad_scanner #(
  parameter int SCAN_DIV       = 65536,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam int            SW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [3:0]    DB_MAX    = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {CLS_NONE, CLS_SINGLE, CLS_MULTI} cls_t;
  typedef enum logic {IDLE, PRESSED} state_t;

  // Row synchronizer
  logic [3:0] row_meta_reg;
  logic [3:0] row_s_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta_reg <= 4'hF;
      row_s_reg    <= 4'hF;
    end else begin
      row_meta_reg <= row;
      row_s_reg    <= row_meta_reg;
    end
  end

  // Slot counter and column index
  logic [SW-1:0] slot_reg;
  logic [1:0]    ci_reg;
  logic          slot_last;
  logic          frame_end;

  assign slot_last = (slot_reg == SLOT_LAST);
  assign frame_end = slot_last && (ci_reg == 2'd3);
  assign col       = ~(4'b0001 << ci_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_reg <= '0;
      ci_reg   <= 2'd0;
    end else if (slot_last) begin
      slot_reg <= '0;
      ci_reg   <= ci_reg + 2'd1;
    end else begin
      slot_reg <= slot_reg + SW'(1);
    end
  end

  // Frame assembly. frame_now already contains the slice being captured this
  // cycle, so at end of frame the classifier sees column 3's fresh sample.
  logic [15:0] frame_reg;
  logic [15:0] frame_now;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slice
      assign frame_now[4*gi+3:4*gi] = (slot_last && (ci_reg == 2'(gi)))
                                      ? ~row_s_reg : frame_reg[4*gi+3:4*gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) frame_reg <= '0;
    else     frame_reg <= frame_now;
  end

  // Frame classification
  logic [4:0] bit_cnt;
  logic [3:0] bit_pos;
  cls_t       cls;
  logic [3:0] code;

  always_comb begin
    bit_cnt = '0;
    bit_pos = '0;
    for (int i = 0; i < 16; i++) begin
      if (frame_now[i]) begin
        bit_cnt = bit_cnt + 5'd1;
        bit_pos = 4'(i);
      end
    end
  end

  always_comb begin
    cls  = CLS_NONE;
    code = 4'd0;   // code is forced to 0 for NONE/MULTI so matching compares class only
    if (bit_cnt == 5'd1) begin
      cls  = CLS_SINGLE;
      code = bit_pos;
    end else if (bit_cnt != 5'd0) begin
      cls = CLS_MULTI;
    end
  end

  // Debounce and press/release FSM
  state_t     state_reg, state_next;
  cls_t       prev_cls_reg, prev_cls_next;
  logic [3:0] prev_code_reg, prev_code_next;
  logic [3:0] stable_reg, stable_next;
  logic [3:0] key_reg, key_next;
  logic       key_valid_reg, key_valid_next;
  logic       key_held_reg, key_held_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      prev_cls_reg  <= CLS_NONE;
      prev_code_reg <= 4'd0;
      stable_reg    <= 4'd0;
      key_reg       <= 4'd0;
      key_valid_reg <= 1'b0;
      key_held_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      prev_cls_reg  <= prev_cls_next;
      prev_code_reg <= prev_code_next;
      stable_reg    <= stable_next;
      key_reg       <= key_next;
      key_valid_reg <= key_valid_next;
      key_held_reg  <= key_held_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    prev_cls_next  = prev_cls_reg;
    prev_code_next = prev_code_reg;
    stable_next    = stable_reg;
    key_next       = key_reg;
    key_valid_next = 1'b0;
    key_held_next  = key_held_reg;
    if (frame_end) begin
      prev_cls_next  = cls;
      prev_code_next = code;
      if ((cls == prev_cls_reg) && (code == prev_code_reg))
        stable_next = (stable_reg >= DB_MAX) ? DB_MAX : stable_reg + 4'd1;
      else
        stable_next = 4'd1;
      // Transitions use the updated count; MULTI never moves the FSM, and a
      // different SINGLE key while PRESSED is not a release.
      if (state_reg == IDLE) begin
        if ((cls == CLS_SINGLE) && (stable_next == DB_MAX)) begin
          state_next     = PRESSED;
          key_next       = code;
          key_valid_next = 1'b1;
          key_held_next  = 1'b1;
        end
      end else begin
        if ((cls == CLS_NONE) && (stable_next == DB_MAX)) begin
          state_next    = IDLE;
          key_held_next = 1'b0;
        end
      end
    end
  end

  assign key       = key_reg;
  assign key_valid = key_valid_reg;
  assign key_held  = key_held_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
// Self-checking bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=2
// (16-cycle frames). A keypad model drives row from col and a pressed-key
// vector. Expected key codes are queued when a qualifying press is applied;
// a monitor pops and compares them on every key_valid pulse.
module tb_keypad_scanner;

  logic        clk;
  logic        rst;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key;
  logic        key_valid;
  logic        key_held;

  logic [15:0] keys;       // bit c*4+r set = key at col c / row r pressed
  int          phase;      // cycle position within the frame, 0..15
  int          total;
  int          bad;
  int          pulse_cnt;
  logic [3:0]  exp_q[$];
  logic [3:0]  exp_v;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .col       (col),
    .key       (key),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix model
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keys[c*4+r] && (col[c] === 1'b0)) row[r] = 1'b0;
  end

  // Bench-side frame phase, restarted by reset
  always @(posedge clk) begin
    if (rst) phase <= 0;
    else     phase <= (phase == 15) ? 0 : phase + 1;
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst && key_valid === 1'b1) begin
      pulse_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse: key_valid=1 key=%b, required no pulse", key);
      end else begin
        exp_v = exp_q.pop_front();
        if (key !== exp_v) begin
          bad++;
          $display("FAIL pulse_key: key=%b required %b", key, exp_v);
        end else begin
          $display("pulse: key=%b", key);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time=%0t required completion", $time);
    $fatal(1, "timeout");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    repeat (16 * n) step();
  endtask

  task automatic align();
    step();
    while (phase != 0) step();
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    rst  = 1'b1;
    keys = 16'h0;
    repeat (3) step();
    total++; if (col !== 4'b1110) begin bad++; $display("FAIL reset_col: col=%b required 1110", col); end
    total++; if (key !== 4'b0000) begin bad++; $display("FAIL reset_key: key=%b required 0000", key); end
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: key_valid=%b required 0", key_valid); end
    total++; if (key_held !== 1'b0) begin bad++; $display("FAIL reset_held: key_held=%b required 0", key_held); end
    rst = 1'b0;
    for (int i = 0; i < 160; i++) begin
      exp_col = ~(4'b0001 << ((i / 4) % 4));
      total++; if (col !== exp_col) begin bad++; $display("FAIL col_seq: cycle %0d col=%b required %b", i, col, exp_col); end
      total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL idle_valid: cycle %0d key_valid=%b required 0", i, key_valid); end
      total++; if (key_held !== 1'b0) begin bad++; $display("FAIL idle_held: cycle %0d key_held=%b required 0", i, key_held); end
      step();
    end
    $display("test_reset: col scan checked over 10 frames");
  endtask

  task automatic test_single_press();
    int p0;
    align();
    p0 = pulse_cnt;
    keys = 16'h0200;
    exp_q.push_back(4'b1001);
    frames(1);
    total++; if (pulse_cnt != p0) begin bad++; $display("FAIL single_early: pulses=%0d required %0d", pulse_cnt - p0, 0); end
    frames(1);
    total++; if (pulse_cnt != p0 + 1) begin bad++; $display("FAIL single_latency: pulses=%0d required %0d", pulse_cnt - p0, 1); end
    total++; if (key !== 4'b1001) begin bad++; $display("FAIL single_key: key=%b required 1001", key); end
    total++; if (key_held !== 1'b1) begin bad++; $display("FAIL single_held: key_held=%b required 1", key_held); end
    frames(3);
    total++; if (pulse_cnt != p0 + 1) begin bad++; $display("FAIL single_repeat: pulses=%0d required %0d", pulse_cnt - p0, 1); end
    total++; if (key_held !== 1'b1) begin bad++; $display("FAIL single_hold5: key_held=%b required 1", key_held); end
    keys = 16'h0;
    frames(1);
    total++; if (key_held !== 1'b1) begin bad++; $display("FAIL single_rel1: key_held=%b required 1", key_held); end
    frames(1);
    total++; if (key_held !== 1'b0) begin bad++; $display("FAIL single_rel2: key_held=%b required 0", key_held); end
    total++; if (key !== 4'b1001) begin bad++; $display("FAIL single_keep: key=%b required 1001", key); end
    frames(1);
    $display("test_single_press: key 9 pressed 5 frames and released");
  endtask

  task automatic test_bounce();
    int p0;
    align();
    p0 = pulse_cnt;
    for (int f = 0; f < 6; f++) begin
      keys = (f % 2 == 0) ? 16'h0200 : 16'h0000;
      frames(1);
      total++; if (pulse_cnt != p0) begin bad++; $display("FAIL bounce_pulse: frame %0d pulses=%0d required 0", f, pulse_cnt - p0); end
      total++; if (key_held !== 1'b0) begin bad++; $display("FAIL bounce_held: frame %0d key_held=%b required 0", f, key_held); end
    end
    keys = 16'h0200;
    exp_q.push_back(4'b1001);
    frames(2);
    total++; if (pulse_cnt != p0 + 1) begin bad++; $display("FAIL bounce_accept: pulses=%0d required 1", pulse_cnt - p0); end
    total++; if (key_held !== 1'b1) begin bad++; $display("FAIL bounce_held_on: key_held=%b required 1", key_held); end
    frames(1);
    keys = 16'h0;
    frames(3);
    total++; if (key_held !== 1'b0) begin bad++; $display("FAIL bounce_release: key_held=%b required 0", key_held); end
    $display("test_bounce: 6 toggling frames then steady press");
  endtask

  task automatic test_multi();
    int p0;
    align();
    p0 = pulse_cnt;
    keys = 16'h8001;
    for (int f = 0; f < 6; f++) begin
      frames(1);
      total++; if (pulse_cnt != p0) begin bad++; $display("FAIL multi_pulse: frame %0d pulses=%0d required 0", f, pulse_cnt - p0); end
      total++; if (key_held !== 1'b0) begin bad++; $display("FAIL multi_held: frame %0d key_held=%b required 0", f, key_held); end
    end
    keys = 16'h0001;
    exp_q.push_back(4'b0000);
    frames(2);
    total++; if (pulse_cnt != p0 + 1) begin bad++; $display("FAIL multi_accept: pulses=%0d required 1", pulse_cnt - p0); end
    total++; if (key !== 4'b0000) begin bad++; $display("FAIL multi_key: key=%b required 0000", key); end
    total++; if (key_held !== 1'b1) begin bad++; $display("FAIL multi_held_on: key_held=%b required 1", key_held); end
    keys = 16'h0;
    frames(3);
    total++; if (key_held !== 1'b0) begin bad++; $display("FAIL multi_release: key_held=%b required 0", key_held); end
    $display("test_multi: keys 0+15 then key 0 alone");
  endtask

  task automatic test_back_to_back();
    int p0;
    align();
    p0 = pulse_cnt;
    keys = 16'h0020;
    exp_q.push_back(4'b0101);
    frames(2);
    total++; if (pulse_cnt != p0 + 1) begin bad++; $display("FAIL b2b_first: pulses=%0d required 1", pulse_cnt - p0); end
    total++; if (key !== 4'b0101) begin bad++; $display("FAIL b2b_key5: key=%b required 0101", key); end
    keys = 16'h0060;
    for (int f = 0; f < 4; f++) begin
      frames(1);
      total++; if (key_held !== 1'b1) begin bad++; $display("FAIL b2b_multi_held: frame %0d key_held=%b required 1", f, key_held); end
    end
    keys = 16'h0040;
    for (int f = 0; f < 4; f++) begin
      frames(1);
      total++; if (key_held !== 1'b1) begin bad++; $display("FAIL b2b_other_held: frame %0d key_held=%b required 1", f, key_held); end
    end
    total++; if (pulse_cnt != p0 + 1) begin bad++; $display("FAIL b2b_no_second: pulses=%0d required 1", pulse_cnt - p0); end
    total++; if (key !== 4'b0101) begin bad++; $display("FAIL b2b_key_kept: key=%b required 0101", key); end
    keys = 16'h0;
    frames(1);
    total++; if (key_held !== 1'b1) begin bad++; $display("FAIL b2b_rel1: key_held=%b required 1", key_held); end
    frames(1);
    total++; if (key_held !== 1'b0) begin bad++; $display("FAIL b2b_rel2: key_held=%b required 0", key_held); end
    keys = 16'h0040;
    exp_q.push_back(4'b0110);
    frames(2);
    total++; if (pulse_cnt != p0 + 2) begin bad++; $display("FAIL b2b_key6: pulses=%0d required 2", pulse_cnt - p0); end
    total++; if (key !== 4'b0110) begin bad++; $display("FAIL b2b_key6_code: key=%b required 0110", key); end
    $display("test_back_to_back: key 5, overlap with 6, release, key 6");
  endtask

  task automatic test_reset_mid();
    int p0;
    keys = 16'h0;
    frames(3);
    align();
    keys = 16'h0200;
    frames(1);
    repeat (8) step();
    rst = 1'b1;
    step();
    total++; if (col !== 4'b1110) begin bad++; $display("FAIL mid_rst_col: col=%b required 1110", col); end
    total++; if (key !== 4'b0000) begin bad++; $display("FAIL mid_rst_key: key=%b required 0000", key); end
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: key_valid=%b required 0", key_valid); end
    total++; if (key_held !== 1'b0) begin bad++; $display("FAIL mid_rst_held: key_held=%b required 0", key_held); end
    rst = 1'b0;
    p0 = pulse_cnt;
    exp_q.push_back(4'b1001);
    frames(1);
    total++; if (pulse_cnt != p0) begin bad++; $display("FAIL mid_rst_early: pulses=%0d required 0", pulse_cnt - p0); end
    frames(1);
    total++; if (pulse_cnt != p0 + 1) begin bad++; $display("FAIL mid_rst_accept: pulses=%0d required 1", pulse_cnt - p0); end
    total++; if (key_held !== 1'b1) begin bad++; $display("FAIL mid_rst_held_on: key_held=%b required 1", key_held); end
    keys = 16'h0;
    frames(3);
    $display("test_reset_mid: reset during second debounce frame");
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    pulse_cnt = 0;
    rst       = 1'b1;
    keys      = 16'h0;
    test_reset();
    test_single_press();
    test_bounce();
    test_multi();
    test_back_to_back();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_expect: %0d expected pulses never seen, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
